// File: rtl/riscv_pkg.sv
// Shared types and constants for the writeback stage: widths, load funct3 codes
// and the load byte/half/word extraction helper.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_LOAD,
      SEL_FIFO,
      SEL_BYPASS
   } wb_sel_e;

   typedef struct packed {
      logic                  reg_write;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       result;
   } wb_item_t;

   // Returns {err, data}; err covers both misalignment and unknown funct3.
   function automatic logic [XLEN:0] load_align(input logic [XLEN-1:0] rdata,
                                                input logic [1:0]      addr_lo,
                                                input logic [2:0]      funct3);
      logic [7:0]      lane_b;
      logic [15:0]     lane_h;
      logic            err;
      logic [XLEN-1:0] data;
      lane_b = 8'(rdata >> {addr_lo, 3'b000});
      lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      err    = 1'b0;
      data   = '0;
      case (funct3)
         LOAD_LB:  data = {{(XLEN-8){lane_b[7]}}, lane_b};
         LOAD_LBU: data = {{(XLEN-8){1'b0}}, lane_b};
         LOAD_LH: begin
            err  = addr_lo[0];
            data = {{(XLEN-16){lane_h[15]}}, lane_h};
         end
         LOAD_LHU: begin
            err  = addr_lo[0];
            data = {{(XLEN-16){1'b0}}, lane_h};
         end
         LOAD_LW: begin
            err  = (addr_lo != 2'b00);
            data = rdata;
         end
         default: err = 1'b1;
      endcase
      return {err, data};
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// ALU result FIFO: power-of-two depth, wrapping pointers, registered count,
// plus a mask of destinations held by valid entries that will write.
module wb_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  push_reg_write,
   input  logic [REG_ADDR_W-1:0] push_rd,
   input  logic [XLEN-1:0]       push_result,
   output logic                  head_reg_write,
   output logic [REG_ADDR_W-1:0] head_rd,
   output logic [XLEN-1:0]       head_result,
   output logic                  full,
   output logic                  empty,
   output logic [31:0]           pend_mask
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   wb_item_t             mem_q [DEPTH];
   wb_item_t             mem_d [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [PTR_W-1:0]     scan_idx;

   assign full           = (count_q == CNT_W'(DEPTH));
   assign empty          = (count_q == '0);
   assign head_reg_write = mem_q[rd_ptr_q].reg_write;
   assign head_rd        = mem_q[rd_ptr_q].rd;
   assign head_result    = mem_q[rd_ptr_q].result;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push && !full) begin
         mem_d[wr_ptr_q] = '{reg_write: push_reg_write, rd: push_rd, result: push_result};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push && !full, pop && !empty})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Walk entries oldest-first; only slots below the live count contribute.
   always_comb begin
      pend_mask = '0;
      scan_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && mem_q[scan_idx].reg_write) begin
            pend_mask[mem_q[scan_idx].rd] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: arbitrates loads against buffered ALU results, drives the
// register-file write port and exports the pending-destination mask.
module writeback_stage
   import riscv_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic                  alu_reg_write,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_result,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [REG_ADDR_W-1:0] ld_rd,
   input  logic [XLEN-1:0]       ld_rdata,
   input  logic [1:0]            ld_addr_lo,
   input  logic [2:0]            ld_funct3,
   output logic                  ld_err,
   output logic                  reg_write,
   output logic [REG_ADDR_W-1:0] write_register,
   output logic [XLEN-1:0]       write_data,
   output logic [31:0]           pend_mask
);

   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic                  head_reg_write;
   logic [REG_ADDR_W-1:0] head_rd;
   logic [XLEN-1:0]       head_result;
   logic [31:0]           fifo_pend;
   logic [XLEN:0]         load_res;
   wb_sel_e               sel;

   logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
   logic                  reg_write_q, reg_write_d;
   logic [REG_ADDR_W-1:0] write_register_q, write_register_d;
   logic [XLEN-1:0]       write_data_q, write_data_d;
   logic                  ld_err_q, ld_err_d;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk            (clk),
      .reset_n        (reset_n),
      .push           (fifo_push),
      .pop            (fifo_pop),
      .push_reg_write (alu_reg_write),
      .push_rd        (alu_rd),
      .push_result    (alu_result),
      .head_reg_write (head_reg_write),
      .head_rd        (head_rd),
      .head_result    (head_result),
      .full           (fifo_full),
      .empty          (fifo_empty),
      .pend_mask      (fifo_pend)
   );

   assign alu_ready = !fifo_full;
   assign ld_ready  = !(!fifo_empty && (starve_cnt_q == STARVE_W'(STARVE_MAX)));
   assign load_res  = load_align(ld_rdata, ld_addr_lo, ld_funct3);

   // A load wins unless the head is starving; an ALU item only bypasses an empty FIFO.
   always_comb begin
      sel = SEL_NONE;
      if (ld_valid && ld_ready) begin
         sel = SEL_LOAD;
      end else if (!fifo_empty) begin
         sel = SEL_FIFO;
      end else if (alu_valid) begin
         sel = SEL_BYPASS;
      end
      fifo_pop  = (sel == SEL_FIFO);
      fifo_push = alu_valid && alu_ready && (sel != SEL_BYPASS);
   end

   always_comb begin
      reg_write_d      = 1'b0;
      write_register_d = write_register_q;
      write_data_d     = write_data_q;
      ld_err_d         = 1'b0;
      starve_cnt_d     = (fifo_pop || fifo_empty) ? '0 : starve_cnt_q + 1'b1;
      case (sel)
         SEL_LOAD: begin
            ld_err_d = load_res[XLEN];
            if (!load_res[XLEN] && (ld_rd != '0)) begin
               reg_write_d      = 1'b1;
               write_register_d = ld_rd;
               write_data_d     = load_res[XLEN-1:0];
            end
         end
         SEL_FIFO: begin
            if (head_reg_write && (head_rd != '0)) begin
               reg_write_d      = 1'b1;
               write_register_d = head_rd;
               write_data_d     = head_result;
            end
         end
         SEL_BYPASS: begin
            if (alu_reg_write && (alu_rd != '0)) begin
               reg_write_d      = 1'b1;
               write_register_d = alu_rd;
               write_data_d     = alu_result;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt_q     <= '0;
         reg_write_q      <= 1'b0;
         write_register_q <= '0;
         write_data_q     <= '0;
         ld_err_q         <= 1'b0;
      end else begin
         starve_cnt_q     <= starve_cnt_d;
         reg_write_q      <= reg_write_d;
         write_register_q <= write_register_d;
         write_data_q     <= write_data_d;
         ld_err_q         <= ld_err_d;
      end
   end

   assign reg_write      = reg_write_q;
   assign write_register = write_register_q;
   assign write_data     = write_data_q;
   assign ld_err         = ld_err_q;

   always_comb begin
      pend_mask = fifo_pend;
      if (reg_write_q) begin
         pend_mask = pend_mask | (32'd1 << write_register_q);
      end
      pend_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: stimulus pushes hand-computed expected writes
// and load errors into a queue; a negedge monitor pops and compares them.
module tb_writeback_stage;
   import riscv_pkg::*;

   typedef struct {
      logic        is_err;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        alu_valid, alu_ready, alu_reg_write;
   logic [4:0]  alu_rd;
   logic [31:0] alu_result;
   logic        ld_valid, ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_rdata;
   logic [1:0]  ld_addr_lo;
   logic [2:0]  ld_funct3;
   logic        ld_err, reg_write;
   logic [4:0]  write_register;
   logic [31:0] write_data;
   logic [31:0] pend_mask;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   writeback_stage #(.FIFO_DEPTH(2), .STARVE_MAX(2)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_reg_write  (alu_reg_write),
      .alu_rd         (alu_rd),
      .alu_result     (alu_result),
      .ld_valid       (ld_valid),
      .ld_ready       (ld_ready),
      .ld_rd          (ld_rd),
      .ld_rdata       (ld_rdata),
      .ld_addr_lo     (ld_addr_lo),
      .ld_funct3      (ld_funct3),
      .ld_err         (ld_err),
      .reg_write      (reg_write),
      .write_register (write_register),
      .write_data     (write_data),
      .pend_mask      (pend_mask)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic lv, input logic [4:0] lrd, input logic [31:0] lrdata,
                                 input logic [1:0] laddr, input logic [2:0] lf3,
                                 input logic av, input logic arw, input logic [4:0] ard,
                                 input logic [31:0] ares);
      ld_valid      = lv;
      ld_rd         = lrd;
      ld_rdata      = lrdata;
      ld_addr_lo    = laddr;
      ld_funct3     = lf3;
      alu_valid     = av;
      alu_reg_write = arw;
      alu_rd        = ard;
      alu_result    = ares;
   endtask

   task automatic idle();
      apply_stimulus(1'b0, 5'd0, 32'd0, 2'd0, LOAD_LW, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
      exp_t e;
      e.is_err = 1'b0;
      e.rd     = rd;
      e.data   = data;
      exp_q.push_back(e);
   endtask

   task automatic expect_err();
      exp_t e;
      e.is_err = 1'b1;
      e.rd     = '0;
      e.data   = '0;
      exp_q.push_back(e);
   endtask

   // Monitor: every write or error pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (reset_n && (reg_write || ld_err)) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL unexpected_output: got reg_write=%0b rd=%0d data=0x%08h ld_err=%0b expected nothing",
                     reg_write, write_register, write_data, ld_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (e.is_err) begin
               if (!(ld_err === 1'b1 && reg_write === 1'b0)) begin
                  n_fail++;
                  $display("[TB] FAIL ld_err_event: got ld_err=%0b reg_write=%0b expected ld_err=1 reg_write=0",
                           ld_err, reg_write);
               end
            end else if (!(reg_write === 1'b1 && ld_err === 1'b0 && write_register === e.rd
                           && write_data === e.data)) begin
               n_fail++;
               $display("[TB] FAIL write_event: got we=%0b err=%0b rd=%0d data=0x%08h expected rd=%0d data=0x%08h",
                        reg_write, ld_err, write_register, write_data, e.rd, e.data);
            end
         end
      end
   end

   localparam logic [31:0] RDATA = 32'h80FF7F01;
   logic [4:0]  t3_rd   [7] = '{5'd4, 5'd6, 5'd3, 5'd2, 5'd14, 5'd15, 5'd16};
   logic [1:0]  t3_addr [7] = '{2'd3, 2'd2, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
   logic [2:0]  t3_f3   [7] = '{LOAD_LB, LOAD_LHU, LOAD_LBU, LOAD_LH, LOAD_LH, LOAD_LW, LOAD_LB};
   logic [31:0] t3_exp  [7] = '{32'hFFFFFF80, 32'h000080FF, 32'h0000007F, 32'hFFFF80FF,
                                32'h00007F01, 32'h80FF7F01, 32'h00000001};

   initial begin
      // Test 1: reset while an ALU item is offered.
      reset_n = 1'b0;
      idle();
      alu_valid     = 1'b1;
      alu_reg_write = 1'b1;
      alu_rd        = 5'd9;
      alu_result    = 32'h99;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_reg_write", 32'(reg_write), 32'd0);
      check_output("reset_pend_mask", pend_mask, 32'd0);
      next_cycle();
      idle();
      reset_n = 1'b1;
      @(negedge clk);
      check_output("post_reset_alu_ready", 32'(alu_ready), 32'd1);
      check_output("post_reset_ld_ready", 32'(ld_ready), 32'd1);
      check_output("post_reset_write_register", 32'(write_register), 32'd0);
      check_output("post_reset_write_data", write_data, 32'd0);
      check_output("post_reset_ld_err", 32'(ld_err), 32'd0);
      next_cycle();

      // Test 2: lone ALU bypass, then a non-writing ALU op.
      apply_stimulus(1'b0, 5'd0, 32'd0, 2'd0, LOAD_LW, 1'b1, 1'b1, 5'd5, 32'h1234);
      expect_write(5'd5, 32'h1234);
      next_cycle();
      apply_stimulus(1'b0, 5'd0, 32'd0, 2'd0, LOAD_LW, 1'b1, 1'b0, 5'd15, 32'hDEAD);
      @(negedge clk);
      check_output("bypass_pend_mask", pend_mask, 32'h0000_0020);
      next_cycle();
      idle();
      @(negedge clk);
      check_output("no_write_reg_write", 32'(reg_write), 32'd0);
      check_output("no_write_hold_rd", 32'(write_register), 32'd5);
      check_output("no_write_hold_data", write_data, 32'h1234);
      next_cycle();

      // Test 3: load extraction table, back to back.
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(1'b1, t3_rd[i], RDATA, t3_addr[i], t3_f3[i], 1'b0, 1'b0, 5'd0, 32'd0);
         expect_write(t3_rd[i], t3_exp[i]);
         next_cycle();
      end
      idle();
      next_cycle();

      // Test 4: misaligned and illegal loads; queued rd=0 ALU item drains silently.
      apply_stimulus(1'b1, 5'd9, RDATA, 2'd2, LOAD_LW, 1'b1, 1'b1, 5'd0, 32'h55);
      expect_err();
      next_cycle();
      apply_stimulus(1'b1, 5'd9, RDATA, 2'd0, 3'b011, 1'b0, 1'b0, 5'd0, 32'd0);
      expect_err();
      @(negedge clk);
      check_output("rd0_entry_pend_mask", pend_mask, 32'd0);
      next_cycle();
      apply_stimulus(1'b1, 5'd9, RDATA, 2'd1, LOAD_LHU, 1'b0, 1'b0, 5'd0, 32'd0);
      expect_err();
      next_cycle();
      idle();
      @(negedge clk);
      check_output("after_err_pend_mask", pend_mask, 32'd0);
      check_output("after_err_alu_ready", 32'(alu_ready), 32'd1);
      next_cycle();

      // Test 5: loads every cycle against ALU items rd=1,2,3.
      apply_stimulus(1'b1, 5'd10, 32'hA0A0A0A0, 2'd0, LOAD_LW, 1'b1, 1'b1, 5'd1, 32'h11);
      expect_write(5'd10, 32'hA0A0A0A0);
      next_cycle();
      apply_stimulus(1'b1, 5'd11, 32'hB1B1B1B1, 2'd0, LOAD_LW, 1'b1, 1'b1, 5'd2, 32'h22);
      expect_write(5'd11, 32'hB1B1B1B1);
      next_cycle();
      apply_stimulus(1'b1, 5'd12, 32'hC2C2C2C2, 2'd0, LOAD_LW, 1'b1, 1'b1, 5'd3, 32'h33);
      expect_write(5'd12, 32'hC2C2C2C2);
      @(negedge clk);
      check_output("full_alu_ready", 32'(alu_ready), 32'd0);
      check_output("full_ld_ready", 32'(ld_ready), 32'd1);
      check_output("full_pend_mask", pend_mask, 32'h0000_0806);
      next_cycle();
      apply_stimulus(1'b1, 5'd13, 32'hD3D3D3D3, 2'd0, LOAD_LW, 1'b1, 1'b1, 5'd3, 32'h33);
      expect_write(5'd1, 32'h11);
      @(negedge clk);
      check_output("starve_ld_ready", 32'(ld_ready), 32'd0);
      check_output("starve_alu_ready", 32'(alu_ready), 32'd0);
      next_cycle();
      expect_write(5'd13, 32'hD3D3D3D3);
      @(negedge clk);
      check_output("post_starve_ld_ready", 32'(ld_ready), 32'd1);
      check_output("post_starve_alu_ready", 32'(alu_ready), 32'd1);
      next_cycle();
      idle();
      expect_write(5'd2, 32'h22);
      expect_write(5'd3, 32'h33);
      repeat (3) next_cycle();

      // Test 6: load and ALU item in the same cycle with an empty FIFO.
      apply_stimulus(1'b1, 5'd7, 32'h77777777, 2'd0, LOAD_LW, 1'b1, 1'b1, 5'd8, 32'h88);
      expect_write(5'd7, 32'h77777777);
      expect_write(5'd8, 32'h88);
      next_cycle();
      idle();
      @(negedge clk);
      check_output("same_cycle_pend_mask", pend_mask, 32'h0000_0180);
      next_cycle();
      @(negedge clk);
      check_output("queued_write_pend_mask", pend_mask, 32'h0000_0100);
      next_cycle();

      // Reset mid-operation: the queued rd=21 item must never be written.
      apply_stimulus(1'b1, 5'd20, 32'h20202020, 2'd0, LOAD_LW, 1'b1, 1'b1, 5'd21, 32'h21);
      expect_write(5'd20, 32'h20202020);
      next_cycle();
      idle();
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check_output("mid_reset_pend_mask", pend_mask, 32'd0);
      check_output("mid_reset_reg_write", 32'(reg_write), 32'd0);
      check_output("mid_reset_write_data", write_data, 32'd0);
      next_cycle();
      reset_n = 1'b1;
      repeat (4) next_cycle();

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         next_cycle();
      end
      check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
